// File: rtl/tlb_lookup_ctrl.sv
// TLB lookup/refill controller: set lookup, page-walk refill, LRU ageing; hit resp 6 cycles after accept, held until resp_ready.
// Optional `TLB_FLUSH_EN adds flush_req/flush_done and a full invalidate sweep (one entry per cycle).
module tlb_lookup_ctrl #(
  parameter int NUM_SETS       = 16,
  parameter int NUM_WAYS       = 4,
  parameter int SET_INDEX_BITS = 4,
  parameter int LRU_BITS       = 4,
  localparam int WAY_BITS      = $clog2(NUM_WAYS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [31:0]                  req_va,
  input  logic                         req_write,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [31:0]                  resp_pa,
  output logic                         resp_hit,
  output logic                         resp_fault,
  output logic [SET_INDEX_BITS-1:0]    rd_set_index,
  input  logic [NUM_WAYS-1:0]          rd_valid,
  input  logic [NUM_WAYS*20-1:0]       rd_vpn,
  input  logic [NUM_WAYS*20-1:0]       rd_ppn,
  input  logic [NUM_WAYS*2-1:0]        rd_perms,
  input  logic [NUM_WAYS*LRU_BITS-1:0] rd_lru_count,
  output logic                         wr_en,
  output logic [SET_INDEX_BITS-1:0]    wr_set_index,
  output logic [WAY_BITS-1:0]          wr_way,
  output logic                         wr_valid,
  output logic [19:0]                  wr_vpn,
  output logic [19:0]                  wr_ppn,
  output logic [1:0]                   wr_perms,
  output logic [LRU_BITS-1:0]          wr_lru_count,
  output logic                         lru_update_en,
  output logic [SET_INDEX_BITS-1:0]    lru_set_index,
  output logic [WAY_BITS-1:0]          lru_way,
  output logic [LRU_BITS-1:0]          lru_value,
  output logic                         ptw_req_valid,
  input  logic                         ptw_req_ready,
  output logic [19:0]                  ptw_vpn,
  input  logic                         ptw_resp_valid,
  input  logic [19:0]                  ptw_resp_ppn,
  input  logic [1:0]                   ptw_resp_perms,
  input  logic                         ptw_resp_fault
`ifdef TLB_FLUSH_EN
  ,
  input  logic                         flush_req,
  output logic                         flush_done
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WALK_REQ,
    ST_WALK_WAIT,
    ST_REFILL,
    ST_AGE,
    ST_RESP
`ifdef TLB_FLUSH_EN
    , ST_FLUSH
`endif
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [31:0]               r_va;
  logic                      r_write;
  logic                      r_hit;
  logic                      r_walk_fault;
  logic                      r_out_en;
  logic [WAY_BITS-1:0]       r_target;
  logic [WAY_BITS-1:0]       r_victim;
  logic [WAY_BITS-1:0]       r_age_k;
  logic [19:0]               r_ppn;
  logic [1:0]                r_perms;
`ifdef TLB_FLUSH_EN
  logic [SET_INDEX_BITS+WAY_BITS-1:0] r_flush_idx;
  logic                      r_flush_done;
`endif

  logic [19:0]               w_vpn;
  logic [SET_INDEX_BITS-1:0] w_set;
  logic                      w_hit;
  logic [WAY_BITS-1:0]       w_hit_way;
  logic                      w_has_invalid;
  logic [WAY_BITS-1:0]       w_inv_way;
  logic [WAY_BITS-1:0]       w_min_way;
  logic [LRU_BITS-1:0]       w_min_cnt;
  logic [WAY_BITS-1:0]       w_victim;
  logic [LRU_BITS-1:0]       w_age_count;
  logic                      w_fault;
  logic                      w_accept;

  assign w_vpn        = r_va[31:12];
  // NUM_SETS is a power of two, so this reduces to the low VPN bits.
  assign w_set        = SET_INDEX_BITS'(w_vpn % NUM_SETS);
  assign rd_set_index = w_set;
  assign w_age_count  = rd_lru_count[LRU_BITS*r_age_k +: LRU_BITS];
  assign w_fault      = r_walk_fault | (r_write ? ~r_perms[1] : ~r_perms[0]);
  assign w_accept     = (r_state == ST_IDLE) && req_valid && req_ready;

  // Descending scans leave the lowest matching/invalid way; strict < keeps the lowest on LRU ties.
  always_comb begin
    w_hit         = 1'b0;
    w_hit_way     = '0;
    w_has_invalid = 1'b0;
    w_inv_way     = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (rd_valid[w] && (rd_vpn[20*w +: 20] == w_vpn)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_BITS'(w);
      end
      if (!rd_valid[w]) begin
        w_has_invalid = 1'b1;
        w_inv_way     = WAY_BITS'(w);
      end
    end
    w_min_way = '0;
    w_min_cnt = rd_lru_count[LRU_BITS-1:0];
    for (int w = 1; w < NUM_WAYS; w++) begin
      if (rd_lru_count[LRU_BITS*w +: LRU_BITS] < w_min_cnt) begin
        w_min_cnt = rd_lru_count[LRU_BITS*w +: LRU_BITS];
        w_min_way = WAY_BITS'(w);
      end
    end
    w_victim = w_has_invalid ? w_inv_way : w_min_way;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_pa       = '0;
    resp_hit      = 1'b0;
    resp_fault    = 1'b0;
    wr_en         = 1'b0;
    wr_set_index  = '0;
    wr_way        = '0;
    wr_valid      = 1'b0;
    wr_vpn        = '0;
    wr_ppn        = '0;
    wr_perms      = '0;
    wr_lru_count  = '0;
    lru_update_en = 1'b0;
    lru_set_index = '0;
    lru_way       = '0;
    lru_value     = '0;
    ptw_req_valid = 1'b0;
    ptw_vpn       = '0;
    case (r_state)
      ST_IDLE: begin
`ifdef TLB_FLUSH_EN
        req_ready = r_out_en && !flush_req;
        if (r_out_en && flush_req) w_next = ST_FLUSH;
        else if (req_valid && req_ready) w_next = ST_LOOKUP;
`else
        req_ready = r_out_en;
        if (req_valid && req_ready) w_next = ST_LOOKUP;
`endif
      end
      ST_LOOKUP: w_next = w_hit ? ST_AGE : ST_WALK_REQ;
      ST_WALK_REQ: begin
        ptw_req_valid = 1'b1;
        ptw_vpn       = w_vpn;
        if (ptw_req_ready) w_next = ST_WALK_WAIT;
      end
      ST_WALK_WAIT: begin
        if (ptw_resp_valid) w_next = ptw_resp_fault ? ST_RESP : ST_REFILL;
      end
      ST_REFILL: begin
        wr_en        = 1'b1;
        wr_set_index = w_set;
        wr_way       = r_victim;
        wr_valid     = 1'b1;
        wr_vpn       = w_vpn;
        wr_ppn       = r_ppn;
        wr_perms     = r_perms;
        wr_lru_count = '0;
        w_next       = ST_AGE;
      end
      ST_AGE: begin
        lru_set_index = w_set;
        lru_way       = r_age_k;
        if (r_age_k == r_target) begin
          lru_update_en = 1'b1;
          lru_value     = '1;
        end else if (w_age_count != '0) begin
          lru_update_en = 1'b1;
          lru_value     = w_age_count - 1'b1;
        end
        if (r_age_k == WAY_BITS'(NUM_WAYS - 1)) w_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_hit   = r_hit;
        resp_fault = w_fault;
        resp_pa    = w_fault ? 32'h0 : {r_ppn, r_va[11:0]};
        if (resp_ready) w_next = ST_IDLE;
      end
`ifdef TLB_FLUSH_EN
      ST_FLUSH: begin
        wr_en        = 1'b1;
        wr_set_index = r_flush_idx[SET_INDEX_BITS+WAY_BITS-1:WAY_BITS];
        wr_way       = r_flush_idx[WAY_BITS-1:0];
        if (&r_flush_idx) w_next = ST_IDLE;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_va         <= '0;
      r_write      <= 1'b0;
      r_hit        <= 1'b0;
      r_walk_fault <= 1'b0;
      r_out_en     <= 1'b0;
      r_target     <= '0;
      r_victim     <= '0;
      r_age_k      <= '0;
      r_ppn        <= '0;
      r_perms      <= '0;
`ifdef TLB_FLUSH_EN
      r_flush_idx  <= '0;
      r_flush_done <= 1'b0;
`endif
    end else begin
      r_out_en <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_va    <= req_va;
            r_write <= req_write;
          end
        end
        ST_LOOKUP: begin
          r_walk_fault <= 1'b0;
          r_hit        <= w_hit;
          r_age_k      <= '0;
          if (w_hit) begin
            r_target <= w_hit_way;
            r_ppn    <= rd_ppn[20*w_hit_way +: 20];
            r_perms  <= rd_perms[2*w_hit_way +: 2];
          end else begin
            r_victim <= w_victim;
          end
        end
        ST_WALK_WAIT: begin
          if (ptw_resp_valid) begin
            if (ptw_resp_fault) begin
              r_walk_fault <= 1'b1;
            end else begin
              r_ppn   <= ptw_resp_ppn;
              r_perms <= ptw_resp_perms;
            end
          end
        end
        ST_REFILL: r_target <= r_victim;
        ST_AGE:    r_age_k  <= r_age_k + 1'b1;
`ifdef TLB_FLUSH_EN
        ST_FLUSH:  r_flush_idx <= r_flush_idx + 1'b1;
`endif
        default: ;
      endcase
`ifdef TLB_FLUSH_EN
      r_flush_done <= (r_state == ST_FLUSH) && (&r_flush_idx);
`endif
    end
  end

`ifdef TLB_FLUSH_EN
  assign flush_done = r_flush_done;
`endif

endmodule

// File: tb/tb_tlb_lookup_ctrl.sv
// Directed bench for tlb_lookup_ctrl with a behavioural storage array and page-walker.
// Define TLB_FLUSH_EN on both files to exercise the flush sweep.
module tb_tlb_lookup_ctrl;
  localparam int NS = 16;
  localparam int NW = 4;
  localparam int SB = 4;
  localparam int LB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, req_valid, req_ready, req_write;
  logic [31:0]   req_va;
  logic          resp_valid, resp_ready, resp_hit, resp_fault;
  logic [31:0]   resp_pa;
  logic [SB-1:0] rd_set_index;
  logic [NW-1:0] rd_valid;
  logic [NW*20-1:0] rd_vpn, rd_ppn;
  logic [NW*2-1:0]  rd_perms;
  logic [NW*LB-1:0] rd_lru_count;
  logic          wr_en, wr_valid;
  logic [SB-1:0] wr_set_index;
  logic [1:0]    wr_way, wr_perms;
  logic [19:0]   wr_vpn, wr_ppn;
  logic [LB-1:0] wr_lru_count;
  logic          lru_update_en;
  logic [SB-1:0] lru_set_index;
  logic [1:0]    lru_way;
  logic [LB-1:0] lru_value;
  logic          ptw_req_valid, ptw_req_ready, ptw_resp_valid, ptw_resp_fault;
  logic [19:0]   ptw_vpn, ptw_resp_ppn;
  logic [1:0]    ptw_resp_perms;
`ifdef TLB_FLUSH_EN
  logic          flush_req, flush_done;
`endif

  tlb_lookup_ctrl u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va), .req_write(req_write),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_pa(resp_pa),
    .resp_hit(resp_hit), .resp_fault(resp_fault),
    .rd_set_index(rd_set_index), .rd_valid(rd_valid), .rd_vpn(rd_vpn), .rd_ppn(rd_ppn),
    .rd_perms(rd_perms), .rd_lru_count(rd_lru_count),
    .wr_en(wr_en), .wr_set_index(wr_set_index), .wr_way(wr_way), .wr_valid(wr_valid),
    .wr_vpn(wr_vpn), .wr_ppn(wr_ppn), .wr_perms(wr_perms), .wr_lru_count(wr_lru_count),
    .lru_update_en(lru_update_en), .lru_set_index(lru_set_index), .lru_way(lru_way),
    .lru_value(lru_value),
    .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready), .ptw_vpn(ptw_vpn),
    .ptw_resp_valid(ptw_resp_valid), .ptw_resp_ppn(ptw_resp_ppn),
    .ptw_resp_perms(ptw_resp_perms), .ptw_resp_fault(ptw_resp_fault)
`ifdef TLB_FLUSH_EN
    , .flush_req(flush_req), .flush_done(flush_done)
`endif
  );

  // Storage array model: combinational read, writes and LRU updates on the clock edge.
  logic          m_valid [NS][NW] = '{default: '0};
  logic [19:0]   m_vpn   [NS][NW] = '{default: '0};
  logic [19:0]   m_ppn   [NS][NW] = '{default: '0};
  logic [1:0]    m_perms [NS][NW] = '{default: '0};
  logic [LB-1:0] m_lru   [NS][NW] = '{default: '0};
  int            wr_cnt = 0;
  int            ptw_cyc = 0;
  int            overlap = 0;
  logic [SB-1:0] last_wr_set = '0;
  logic [1:0]    last_wr_way = '0;

  always_comb begin
    rd_valid = '0; rd_vpn = '0; rd_ppn = '0; rd_perms = '0; rd_lru_count = '0;
    for (int w = 0; w < NW; w++) begin
      rd_valid[w]             = m_valid[rd_set_index][w];
      rd_vpn[20*w +: 20]      = m_vpn[rd_set_index][w];
      rd_ppn[20*w +: 20]      = m_ppn[rd_set_index][w];
      rd_perms[2*w +: 2]      = m_perms[rd_set_index][w];
      rd_lru_count[LB*w +: LB] = m_lru[rd_set_index][w];
    end
  end

  always @(posedge clk) begin
    if (wr_en) begin
      m_valid[wr_set_index][wr_way] <= wr_valid;
      m_vpn[wr_set_index][wr_way]   <= wr_vpn;
      m_ppn[wr_set_index][wr_way]   <= wr_ppn;
      m_perms[wr_set_index][wr_way] <= wr_perms;
      m_lru[wr_set_index][wr_way]   <= wr_lru_count;
      wr_cnt      <= wr_cnt + 1;
      last_wr_set <= wr_set_index;
      last_wr_way <= wr_way;
    end
    if (lru_update_en) m_lru[lru_set_index][lru_way] <= lru_value;
    if (wr_en && lru_update_en) overlap <= overlap + 1;
    if (ptw_req_valid) ptw_cyc <= ptw_cyc + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] t_pa;
  logic        t_hit, t_fault, t_walked, t_tmo;
  logic [19:0] t_vpn;
  int          t_lat;

  // One full transaction; answers the walk with (ppn, perms, pf) and holds resp_ready low for 'hold' cycles.
  task automatic txn(input logic [31:0] va, input logic wr, input logic [19:0] ppn,
                     input logic [1:0] perms, input logic pf, input int hold);
    int  n;
    bit  done;
    t_walked = 1'b0; t_tmo = 1'b0; t_lat = 0; t_vpn = '0;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_va = va; req_write = wr; req_valid = 1'b1;
    resp_ready = (hold == 0);
    @(negedge clk);
    req_valid = 1'b0;
    done = 1'b0;
    for (int c = 1; c <= 200 && !done; c++) begin
      if (resp_valid) begin
        ptw_resp_valid = 1'b0;
        t_lat = c; t_pa = resp_pa; t_hit = resp_hit; t_fault = resp_fault;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          chk("bp_valid", 32'(resp_valid), 32'd1);
          chk("bp_pa",    resp_pa, t_pa);
          chk("bp_hit",   32'(resp_hit), 32'(t_hit));
          chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        done = 1'b1;
      end else begin
        if (ptw_req_valid && !ptw_req_ready) begin
          t_walked = 1'b1; t_vpn = ptw_vpn; ptw_req_ready = 1'b1;
        end else if (ptw_req_ready) begin
          ptw_req_ready = 1'b0;
          ptw_resp_valid = 1'b1; ptw_resp_ppn = ppn; ptw_resp_perms = perms; ptw_resp_fault = pf;
        end else if (ptw_resp_valid) begin
          ptw_resp_valid = 1'b0;
        end
        @(negedge clk);
      end
    end
    if (!done) t_tmo = 1'b1;
    chk("txn_timeout", 32'(t_tmo), 32'd0);
  endtask

  int w0, p0, n, nv;
  logic tmo, seen;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_va = '0; req_write = 1'b0; resp_ready = 1'b1;
    ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0; ptw_resp_ppn = '0;
    ptw_resp_perms = '0; ptw_resp_fault = 1'b0;
`ifdef TLB_FLUSH_EN
    flush_req = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_ptw_req",    32'(ptw_req_valid), 32'd0);
    chk("rst_wr_en",      32'(wr_en), 32'd0);
    chk("rst_lru_en",     32'(lru_update_en), 32'd0);
    chk("rst_resp_pa",    resp_pa, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready",  32'(req_ready), 32'd1);
    chk("rst_set_index",  32'(rd_set_index), 32'd0);

    // Cold miss
    w0 = wr_cnt;
    txn(32'hABCDE123, 1'b0, 20'h12345, 2'b11, 1'b0, 0);
    chk("cold_walked",  32'(t_walked), 32'd1);
    chk("cold_ptw_vpn", 32'(t_vpn), 32'h000ABCDE);
    chk("cold_wr_cnt",  32'(wr_cnt - w0), 32'd1);
    chk("cold_wr_set",  32'(last_wr_set), 32'hE);
    chk("cold_wr_way",  32'(last_wr_way), 32'd0);
    chk("cold_pa",      t_pa, 32'h12345123);
    chk("cold_hit",     32'(t_hit), 32'd0);
    chk("cold_fault",   32'(t_fault), 32'd0);
    chk("cold_lru",     32'(m_lru[14][0]), 32'd15);

    // Hit
    p0 = ptw_cyc;
    txn(32'hABCDE123, 1'b0, 20'h0, 2'b00, 1'b0, 0);
    chk("hit_no_walk", 32'(ptw_cyc - p0), 32'd0);
    chk("hit_latency", 32'(t_lat), 32'd6);
    chk("hit_hit",     32'(t_hit), 32'd1);
    chk("hit_pa",      t_pa, 32'h12345123);

    // LRU fill of set 3, then a hit on way 0, then a miss choosing way 1
    txn(32'h00003000, 1'b0, 20'h00100, 2'b01, 1'b0, 0);
    txn(32'h00013000, 1'b0, 20'h00101, 2'b11, 1'b0, 0);
    txn(32'h00023000, 1'b0, 20'h00102, 2'b11, 1'b0, 0);
    txn(32'h00033000, 1'b0, 20'h00103, 2'b11, 1'b0, 0);
    chk("lru_fill", 32'({m_lru[3][3], m_lru[3][2], m_lru[3][1], m_lru[3][0]}), 32'h0000FEDC);
    txn(32'h00003010, 1'b0, 20'h0, 2'b00, 1'b0, 0);
    chk("lru_hit_hit", 32'(t_hit), 32'd1);
    chk("lru_hit_pa",  t_pa, 32'h00100010);
    chk("lru_after_hit", 32'({m_lru[3][3], m_lru[3][2], m_lru[3][1], m_lru[3][0]}), 32'h0000EDCF);
    txn(32'h00043000, 1'b0, 20'h00104, 2'b11, 1'b0, 0);
    chk("victim_way", 32'(last_wr_way), 32'd1);
    chk("victim_set", 32'(last_wr_set), 32'd3);
    chk("victim_hit", 32'(t_hit), 32'd0);

    // Store to a read-only entry
    txn(32'h00003ABC, 1'b1, 20'h0, 2'b00, 1'b0, 0);
    chk("perm_hit",   32'(t_hit), 32'd1);
    chk("perm_fault", 32'(t_fault), 32'd1);
    chk("perm_pa",    t_pa, 32'd0);

    // Walk fault: no refill
    w0 = wr_cnt;
    txn(32'h55555000, 1'b0, 20'h0, 2'b11, 1'b1, 0);
    chk("wf_fault",  32'(t_fault), 32'd1);
    chk("wf_hit",    32'(t_hit), 32'd0);
    chk("wf_pa",     t_pa, 32'd0);
    chk("wf_no_wr",  32'(wr_cnt - w0), 32'd0);

    // Response backpressure
    txn(32'hABCDE456, 1'b0, 20'h0, 2'b00, 1'b0, 3);
    chk("bp_hit_final", 32'(t_hit), 32'd1);
    chk("bp_pa_final",  t_pa, 32'h12345456);

    // Reset while waiting for the walk
    @(negedge clk);
    req_va = 32'h77777000; req_write = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!ptw_req_valid && n < 50) begin @(negedge clk); n++; end
    tmo = (n >= 50);
    chk("rw_ptw_timeout", 32'(tmo), 32'd0);
    ptw_req_ready = 1'b1;
    @(negedge clk);
    ptw_req_ready = 1'b0;
    w0 = wr_cnt;
    rst = 1'b0;
    @(negedge clk);
    chk("rw_ptw_req",  32'(ptw_req_valid), 32'd0);
    chk("rw_resp_vld", 32'(resp_valid), 32'd0);
    chk("rw_set_idx",  32'(rd_set_index), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    ptw_resp_valid = 1'b1; ptw_resp_ppn = 20'h99999; ptw_resp_perms = 2'b11; ptw_resp_fault = 1'b0;
    @(negedge clk);
    ptw_resp_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("rw_no_wr",    32'(wr_cnt - w0), 32'd0);
    chk("rw_idle_vld", 32'(resp_valid), 32'd0);
    chk("rw_idle_rdy", 32'(req_ready), 32'd1);

`ifdef TLB_FLUSH_EN
    w0 = wr_cnt;
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    chk("fl_req_ready", 32'(req_ready), 32'd0);
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (flush_done) seen = 1'b1;
    end
    chk("fl_done_seen", 32'(seen), 32'd1);
    chk("fl_wr_cnt",    32'(wr_cnt - w0), 32'd64);
    @(negedge clk);
    chk("fl_done_pulse", 32'(flush_done), 32'd0);
    nv = 0;
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) nv += int'(m_valid[s][w]);
    chk("fl_all_invalid", 32'(nv), 32'd0);
    txn(32'hABCDE123, 1'b0, 20'h12345, 2'b11, 1'b0, 0);
    chk("fl_then_miss", 32'(t_walked), 32'd1);
    chk("fl_miss_hit",  32'(t_hit), 32'd0);
`endif

    chk("wr_lru_exclusive", 32'(overlap), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
